genius_round_ctrl: RTL and testbench
====================================

Name: genius_round_ctrl

Overview:
- Round sequencer for the Genius memory game.
- Plays the stored colour sequence on the LEDs, then collects player button presses and checks each one against the sequence.
- Sequences the 4-bit time counter (decade counter with end_time pulse) through its reset and enable inputs, so every display phase and every input window lasts one counter period.
- Sits between the button/LED front end, the sequence ROM and the time counter instance.

Parameters:
- LEVEL_W, 4, width of the level and sequence-index registers.
- MAX_LEVEL, 15, last level index; completing it wins the game. Must be at most 2^LEVEL_W - 1.

Ports:
- CLKT  in  1  time clock shared with the time counter.
- R  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse that begins a new game.
- BTN  in  4  button press pulses, one-hot, one cycle per press, already synchronised.
- SEQ_DATA  in  2  colour index at SEQ_ADDR; combinational ROM, valid in the same cycle.
- END_TIME  in  1  end_time from the time counter.
- SEQ_ADDR  out  LEVEL_W  sequence index being shown or checked.
- LED  out  4  one-hot colour display.
- TIME_R  out  1  drives the time counter R input.
- TIME_E  out  1  drives the time counter E input.
- LEVEL  out  LEVEL_W  current level; the round length is LEVEL+1.
- STATE  out  3  debug state code.
- WIN  out  1  game won, held.
- LOSE  out  1  game lost, held.

Behaviour:
- One clock (CLKT); reset is asynchronous and active-high on R. All outputs are registered.
- Reset values: STATE=IDLE, LED=0, SEQ_ADDR=0, LEVEL=0, TIME_R=1, TIME_E=0, WIN=0, LOSE=0, internal idx=0.
- State codes: IDLE=0, SHOW_ON=1, SHOW_OFF=2, WAIT_IN=3, NEXT_LVL=4, WIN=5, LOSE=6.
- Timed states are SHOW_ON, SHOW_OFF and WAIT_IN.
- Timer protocol:
  - On every entry into a timed state, including re-entry of WAIT_IN, the first cycle (clear cycle) has TIME_R=1 and TIME_E=0.
  - After the clear cycle, TIME_R=0 and TIME_E=1 until the state is left.
  - END_TIME is ignored during the clear cycle.
  - In all non-timed states, TIME_R=1 and TIME_E=0.
  - With the companion counter, a timed phase with no other event lasts exactly 12 cycles: 1 clear cycle, 10 counting cycles, and 1 cycle in which END_TIME is sampled high.
- IDLE: START → SHOW_ON with LEVEL=0 and idx=0. BTN is ignored.
- SHOW_ON:
  - SEQ_ADDR=idx and LED=onehot(SEQ_DATA).
  - END_TIME → SHOW_OFF.
- SHOW_OFF:
  - LED=0.
  - On END_TIME: if idx==LEVEL, go to WAIT_IN with idx=0; otherwise idx+1 and go to SHOW_ON.
- WAIT_IN: SEQ_ADDR=idx and LED=0.
  - BTN≠0 and BTN==onehot(SEQ_DATA): if idx==LEVEL, go to NEXT_LVL; otherwise idx+1 and re-enter WAIT_IN, which restarts the timer.
  - BTN≠0 and mismatched (including multi-hot) → LOSE.
  - END_TIME with BTN=0 → LOSE (timeout).
  - BTN and END_TIME in the same cycle: BTN takes priority.
- NEXT_LVL: lasts one cycle. If LEVEL==MAX_LEVEL → WIN; otherwise LEVEL+1, idx=0 → SHOW_ON.
- WIN: WIN=1 and LED=4'b1111, both held.
- LOSE: LOSE=1 and LED=0, held.
- START in WIN or LOSE: clears WIN, LOSE, LEVEL and idx, then goes to SHOW_ON.
- START in any other state: ignored. BTN outside WAIT_IN: ignored.
- idx never exceeds LEVEL; LEVEL never exceeds MAX_LEVEL, so there is no wrap.
- R asserted mid-game: immediate return to the reset values.
- TIME_R=1 during reset so the counter is held cleared.

Test Plan:
- Reset then START, with SEQ_DATA for address 0 = 2:
  - SHOW_ON entered with TIME_R=1 for exactly 1 cycle.
  - LED=4'b0100 for 12 cycles, then LED=0 for 12 cycles, then STATE=3.
- Level 0, correct BTN=4'b0100 in cycle 5 of WAIT_IN → NEXT_LVL, then LEVEL=1; SHOW_ON shows addresses 0 and 1 in order.
- WAIT_IN with no press → LOSE=1 exactly 12 cycles after WAIT_IN entry, LED=0, TIME_R=1.
- WAIT_IN with wrong BTN=4'b0001 (expected 4'b1000) → LOSE next cycle. Separately, BTN=4'b0011 → LOSE. Separately, correct BTN coinciding with END_TIME → advance, no LOSE.
- MAX_LEVEL=1 with all presses correct → WIN=1 and LED=4'b1111 after the level-1 round; START → WIN=0, LEVEL=0, STATE=1.
- R pulsed during SHOW_ON at level 2 → all outputs return to reset values within the same cycle; START is required to resume.

Source files
------------

// File: rtl/genius_round_ctrl.sv
// genius_round_ctrl: round sequencer for the Genius memory game.
//   It shows the stored colour sequence on the LEDs. It then collects the
//   player's button presses and checks each one against the sequence.
//   The external decade time counter is driven through TIME_R and TIME_E.
//   Each display phase and each input window therefore lasts one counter
//   period.
// Ports:
//   CLKT      time clock, shared with the time counter
//   R         asynchronous active-high reset
//   START     one-cycle pulse that begins a new game
//   BTN       one-hot button press pulses, already synchronised
//   SEQ_DATA  colour index at SEQ_ADDR (combinational ROM)
//   END_TIME  end_time pulse from the time counter
//   SEQ_ADDR  sequence index being shown or checked
//   LED       one-hot colour display
//   TIME_R    time counter clear
//   TIME_E    time counter enable
//   LEVEL     current level (round length is LEVEL+1)
//   STATE     debug state code
//   WIN/LOSE  held game result flags
module genius_round_ctrl #(
  parameter int unsigned LEVEL_W   = 4,
  parameter int unsigned MAX_LEVEL = 15
) (
  input  logic               CLKT,
  input  logic               R,
  input  logic               START,
  input  logic [3:0]         BTN,
  input  logic [1:0]         SEQ_DATA,
  input  logic               END_TIME,
  output logic [LEVEL_W-1:0] SEQ_ADDR,
  output logic [3:0]         LED,
  output logic               TIME_R,
  output logic               TIME_E,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic [2:0]         STATE,
  output logic               WIN,
  output logic               LOSE
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_ON  = 3'd1,
    S_SHOW_OFF = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_NEXT_LVL = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] ONE     = LEVEL_W'(1);

  state_t               state, state_n;
  logic [LEVEL_W-1:0]   idx, idx_n, level_n, addr_n;
  logic [3:0]           seq_oh, led_n;
  logic                 restart, end_ok, timed_n, enter_n;

  always_comb begin
    seq_oh  = 4'b0001 << SEQ_DATA;
    // Inside a timed state, TIME_R is high only during the clear cycle.
    // A stale END_TIME seen in that cycle is therefore discarded.
    end_ok  = END_TIME && !TIME_R;
    state_n = state;
    idx_n   = idx;
    level_n = LEVEL;
    restart = 1'b0;

    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (START) begin
          state_n = S_SHOW_ON;
          idx_n   = '0;
          level_n = '0;
        end
      end
      S_SHOW_ON: begin
        if (end_ok) state_n = S_SHOW_OFF;
      end
      S_SHOW_OFF: begin
        if (end_ok) begin
          if (idx == LEVEL) begin
            state_n = S_WAIT_IN;
            idx_n   = '0;
          end else begin
            state_n = S_SHOW_ON;
            idx_n   = idx + ONE;
          end
        end
      end
      S_WAIT_IN: begin
        // A button press takes priority over a coincident timeout.
        if (BTN != '0) begin
          if (BTN == seq_oh) begin
            if (idx == LEVEL) begin
              state_n = S_NEXT_LVL;
            end else begin
              idx_n   = idx + ONE;
              restart = 1'b1;
            end
          end else begin
            state_n = S_LOSE;
          end
        end else if (end_ok) begin
          state_n = S_LOSE;
        end
      end
      S_NEXT_LVL: begin
        if (LEVEL == MAX_LVL) begin
          state_n = S_WIN;
        end else begin
          state_n = S_SHOW_ON;
          level_n = LEVEL + ONE;
          idx_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    timed_n = (state_n == S_SHOW_ON) || (state_n == S_SHOW_OFF) ||
              (state_n == S_WAIT_IN);
    enter_n = (state_n != state) || restart;

    // SEQ_ADDR runs one step ahead during SHOW_OFF and NEXT_LVL.
    // The ROM word for the next SHOW_ON is then already on SEQ_DATA in
    // the cycle in which the registered LED is loaded.
    case (state_n)
      S_SHOW_ON, S_WAIT_IN: addr_n = idx_n;
      S_SHOW_OFF:           addr_n = (idx_n == level_n) ? '0 : idx_n + ONE;
      default:              addr_n = '0;
    endcase

    case (state_n)
      S_SHOW_ON: led_n = seq_oh;
      S_WIN:     led_n = '1;
      default:   led_n = '0;
    endcase
  end

  always_ff @(posedge CLKT or posedge R) begin
    if (R) begin
      state    <= S_IDLE;
      idx      <= '0;
      LEVEL    <= '0;
      SEQ_ADDR <= '0;
      LED      <= '0;
      TIME_R   <= 1'b1;
      TIME_E   <= 1'b0;
      WIN      <= 1'b0;
      LOSE     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      LEVEL    <= level_n;
      SEQ_ADDR <= addr_n;
      LED      <= led_n;
      TIME_R   <= !timed_n || enter_n;
      TIME_E   <= timed_n && !enter_n;
      WIN      <= (state_n == S_WIN);
      LOSE     <= (state_n == S_LOSE);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Self-checking bench for genius_round_ctrl.
// Each instance is paired with a behavioural decade time counter.
// Expectations are derived phase by phase from the game rules and a
// random sequence ROM. Instance dut_a uses the default MAX_LEVEL and
// dut_b uses MAX_LEVEL=1. The variable sel picks the instance that is
// driven and observed.
module tb_genius_round_ctrl;

  logic       CLKT;
  logic       R;
  logic       start;
  logic [3:0] btn;
  logic       sel;
  logic [1:0] rom [0:15];

  logic [3:0] a_addr, a_led, a_level, b_addr, b_led, b_level;
  logic [2:0] a_state, b_state;
  logic       a_tr, a_te, a_win, a_lose, b_tr, b_te, b_win, b_lose;
  logic       a_start, b_start, a_end, b_end;
  logic [3:0] a_btn, b_btn, a_cnt, b_cnt;
  logic [1:0] a_data, b_data;

  logic [3:0] o_addr, o_led, o_level;
  logic [2:0] o_state;
  logic       o_tr, o_te, o_win, o_lose;

  int unsigned vectors, miscompares, cyc;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign a_btn   = sel ? 4'b0000 : btn;
  assign b_btn   = sel ? btn : 4'b0000;
  assign a_data  = rom[a_addr];
  assign b_data  = rom[b_addr];

  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_led   = sel ? b_led   : a_led;
  assign o_level = sel ? b_level : a_level;
  assign o_state = sel ? b_state : a_state;
  assign o_tr    = sel ? b_tr    : a_tr;
  assign o_te    = sel ? b_te    : a_te;
  assign o_win   = sel ? b_win   : a_win;
  assign o_lose  = sel ? b_lose  : a_lose;

  genius_round_ctrl dut_a (
    .CLKT(CLKT), .R(R), .START(a_start), .BTN(a_btn), .SEQ_DATA(a_data),
    .END_TIME(a_end), .SEQ_ADDR(a_addr), .LED(a_led), .TIME_R(a_tr),
    .TIME_E(a_te), .LEVEL(a_level), .STATE(a_state), .WIN(a_win), .LOSE(a_lose)
  );

  genius_round_ctrl #(.LEVEL_W(4), .MAX_LEVEL(1)) dut_b (
    .CLKT(CLKT), .R(R), .START(b_start), .BTN(b_btn), .SEQ_DATA(b_data),
    .END_TIME(b_end), .SEQ_ADDR(b_addr), .LED(b_led), .TIME_R(b_tr),
    .TIME_E(b_te), .LEVEL(b_level), .STATE(b_state), .WIN(b_win), .LOSE(b_lose)
  );

  // Companion decade counter: one-cycle end_time after 10 enabled counts
  always_ff @(posedge CLKT or posedge R) begin
    if (R || a_tr) begin
      a_cnt <= '0; a_end <= 1'b0;
    end else if (a_te) begin
      a_end <= (a_cnt == 4'd9);
      a_cnt <= (a_cnt == 4'd9) ? 4'd0 : a_cnt + 4'd1;
    end else begin
      a_end <= 1'b0;
    end
  end

  always_ff @(posedge CLKT or posedge R) begin
    if (R || b_tr) begin
      b_cnt <= '0; b_end <= 1'b0;
    end else if (b_te) begin
      b_end <= (b_cnt == 4'd9);
      b_cnt <= (b_cnt == 4'd9) ? 4'd0 : b_cnt + 4'd1;
    end else begin
      b_end <= 1'b0;
    end
  end

  initial CLKT = 1'b0;
  always #5 CLKT = ~CLKT;

  function automatic logic [3:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLKT);
    #1;
    start = 1'b0;
    btn   = 4'b0000;
    cyc++;
    if (cyc > 30000) begin
      $display("FAIL timeout: observed %0d cycles expected under 30000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic check_cycle(input string tag, input int st, input logic [3:0] led,
                             input bit first, input int lvl);
    bit timed;
    timed = (st >= 1) && (st <= 3);
    chk({tag, ".state"},  o_state, st);
    chk({tag, ".led"},    o_led, led);
    chk({tag, ".time_r"}, o_tr, !timed || first);
    chk({tag, ".time_e"}, o_te, timed && !first);
    chk({tag, ".level"},  o_level, lvl);
    chk({tag, ".win"},    o_win, st == 5);
    chk({tag, ".lose"},   o_lose, st == 6);
  endtask

  // Random presses and START pulses that must be ignored outside WAIT_IN
  task automatic noise(input bit allow_start);
    if ($urandom_range(0, 3) == 0) btn = 4'($urandom_range(1, 15));
    if (allow_start && $urandom_range(0, 7) == 0) start = 1'b1;
  endtask

  // Begins at SHOW_ON cycle 1 of idx 0. Ends at WAIT_IN cycle 1.
  // With cut_idx >= 0, returns early at SHOW_ON cycle 6 of that index.
  task automatic show_round(input int lvl, input int cut_idx);
    for (int i = 0; i <= lvl; i++) begin
      for (int c = 1; c <= 12; c++) begin
        if (i == cut_idx && c == 6) return;
        check_cycle("show_on", 1, oh(rom[i]), c == 1, lvl);
        chk("show_on.addr", o_addr, i);
        noise(1'b1);
        tick();
      end
      for (int c = 1; c <= 12; c++) begin
        check_cycle("show_off", 2, 4'b0000, c == 1, lvl);
        noise(1'b1);
        tick();
      end
    end
  endtask

  // Waits in WAIT_IN for index i and presses b in cycle 'at' (1..12)
  task automatic press(input int lvl, input int i, input int at, input logic [3:0] b);
    for (int c = 1; c <= at; c++) begin
      check_cycle("wait_in", 3, 4'b0000, c == 1, lvl);
      chk("wait_in.addr", o_addr, i);
      if (c == at) btn = b;
      tick();
    end
  endtask

  task automatic answer_round(input int lvl);
    for (int i = 0; i <= lvl; i++)
      press(lvl, i, int'($urandom_range(1, 12)), oh(rom[i]));
    check_cycle("next_lvl", 4, 4'b0000, 1'b0, lvl);
    tick();
  endtask

  task automatic expect_lose(input string tag, input int lvl);
    for (int k = 0; k < 3; k++) begin
      check_cycle(tag, 6, 4'b0000, 1'b0, lvl);
      chk({tag, ".addr"}, o_addr, 0);
      noise(1'b0);
      tick();
    end
  endtask

  task automatic new_rom();
    for (int i = 0; i < 16; i++) rom[i] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    logic [3:0] bad;
    vectors = 0; miscompares = 0; cyc = 0;
    R = 1'b1; start = 1'b0; btn = 4'b0000; sel = 1'b0;
    new_rom();
    rom[0] = 2'd2;

    // Reset values, while reset is held and after it is released
    tick(); tick();
    check_cycle("reset", 0, 4'b0000, 1'b0, 0);
    chk("reset.addr", o_addr, 0);
    R = 1'b0;
    tick();
    check_cycle("idle", 0, 4'b0000, 1'b0, 0);
    btn = 4'b0100;
    tick();
    check_cycle("idle_btn", 0, 4'b0000, 1'b0, 0);

    // Level 0: correct press in WAIT_IN cycle 5
    start = 1'b1; tick();
    show_round(0, -1);
    press(0, 0, 5, 4'b0100);
    check_cycle("next_lvl0", 4, 4'b0000, 1'b0, 0);
    tick();

    // Level 1: second press coincides with END_TIME
    show_round(1, -1);
    press(1, 0, int'($urandom_range(1, 12)), oh(rom[0]));
    press(1, 1, 12, oh(rom[1]));
    check_cycle("next_lvl1", 4, 4'b0000, 1'b0, 1);
    tick();

    // Level 2: asynchronous reset in the middle of SHOW_ON
    show_round(2, 1);
    check_cycle("pre_reset", 1, oh(rom[1]), 1'b0, 2);
    #1 R = 1'b1;
    #1;
    check_cycle("async_reset", 0, 4'b0000, 1'b0, 0);
    chk("async_reset.addr", o_addr, 0);
    tick();
    R = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_cycle("idle_after_reset", 0, 4'b0000, 1'b0, 0);
      noise(1'b0);
      tick();
    end

    // Timeout: LOSE exactly 12 cycles after WAIT_IN entry
    new_rom();
    start = 1'b1; tick();
    show_round(0, -1);
    for (int c = 1; c <= 12; c++) begin
      check_cycle("timeout_wait", 3, 4'b0000, c == 1, 0);
      tick();
    end
    expect_lose("timeout_lose", 0);

    // Wrong single press (0001 where 1000 is expected)
    rom[0] = 2'd3;
    start = 1'b1; tick();
    show_round(0, -1);
    press(0, 0, int'($urandom_range(1, 12)), 4'b0001);
    expect_lose("wrong_lose", 0);

    // Multi-hot press
    start = 1'b1; tick();
    show_round(0, -1);
    press(0, 0, int'($urandom_range(1, 12)), 4'b0011);
    expect_lose("multihot_lose", 0);

    // Random sequences: clear level 0, then miss on the second press of level 1
    for (int n = 0; n < 4; n++) begin
      new_rom();
      start = 1'b1; tick();
      show_round(0, -1);
      answer_round(0);
      show_round(1, -1);
      press(1, 0, int'($urandom_range(1, 12)), oh(rom[0]));
      bad = 4'($urandom_range(1, 15));
      while (bad == oh(rom[1])) bad = 4'($urandom_range(1, 15));
      press(1, 1, int'($urandom_range(1, 12)), bad);
      expect_lose("rand_lose", 1);
    end

    // MAX_LEVEL=1 instance: win after the level-1 round, then restart
    sel = 1'b1;
    new_rom();
    tick();
    check_cycle("b_idle", 0, 4'b0000, 1'b0, 0);
    start = 1'b1; tick();
    show_round(0, -1);
    answer_round(0);
    show_round(1, -1);
    answer_round(1);
    for (int k = 0; k < 3; k++) begin
      check_cycle("win", 5, 4'b1111, 1'b0, 1);
      noise(1'b0);
      tick();
    end
    start = 1'b1; tick();
    check_cycle("restart", 1, oh(rom[0]), 1'b1, 0);
    chk("restart.addr", o_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
